// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one add8 ripple adder.
// One result every 9 cycles, with a start/busy/done handshake and a registered 16-bit product.

module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);
  logic carry;

  // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latches are inferred.
  always_comb begin
    carry = c_in;
    sum   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end
endmodule

module mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  mcand;
  logic [15:0] p;      // upper byte = accumulator, lower byte = multiplier / low product bits
  logic [3:0]  count;
  logic [7:0]  add_b;
  logic [7:0]  sum;
  logic        c_out;
  logic [15:0] p_next;

  assign add_b = p[0] ? mcand : 8'h00;

  add8 u_add8 (
    .a     (p[15:8]),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // The 9-bit {c_out,sum} shifts right with the multiplier, so the carry lands in bit 15.
  assign p_next = {c_out, sum, p[7:1]};

  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= 8'h00;
      p       <= 16'h0000;
      count   <= 4'd0;
      product <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          p     <= p_next;
          count <= count + 4'd1;
          if (count == 4'd7) begin
            product <= p_next;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
          done <= 1'b0;
          if (start) begin
            mcand <= A;
            p     <= {8'h00, B};
            count <= 4'd0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
